// File: rtl/sevenseg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan_ctrl_if
//  Purpose  : Digit-write valid/ready port for the seven-segment scan
//             controller.
//  Signals  : wr_valid  write request (master -> slave)
//             wr_ready  write accepted when wr_valid & wr_ready (slave -> master)
//             wr_idx    target digit, 0 = rightmost / least significant
//             wr_data   hex value 0..F
//             wr_dp     decimal point on for that digit
//  Revision : 1.0  initial release
// ============================================================================
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_data;
    logic             wr_dp;

    modport master (
        output wr_valid,
        output wr_idx,
        output wr_data,
        output wr_dp,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_idx,
        input  wr_data,
        input  wr_dp,
        output wr_ready
    );
endinterface
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for an N-digit common-anode
//             seven-segment display. Per-digit hex values are written into a
//             shadow buffer, copied to the active buffer at each frame
//             boundary, decoded to active-low segments and scanned one digit
//             per slot with a blanking gap at the start of every slot.
//  Ports    : clk           rising-edge clock
//             rst_n         asynchronous active-low reset
//             wr_if         digit write port (slave modport)
//             a..g, dp      segment / decimal point drives, active-low
//             dig_en_n      digit enables, active-low, at most one low
//             frame_start   1-cycle pulse on the first blank cycle of digit 0
//                           after a buffer commit
//  Options  : SEVENSEG_LZS_EN  define to enable leading-zero suppression
//  Revision : 1.0  initial release
// ============================================================================
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 12000,
    parameter int BLANK_CYCLES = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    sevenseg_scan_ctrl_if.slave        wr_if,
    output logic                       a,
    output logic                       b,
    output logic                       c,
    output logic                       d,
    output logic                       e,
    output logic                       f,
    output logic                       g,
    output logic                       dp,
    output logic [NUM_DIGITS-1:0]      dig_en_n,
    output logic                       frame_start
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(SLOT_CYCLES);

    localparam logic [CNT_W-1:0] c_cnt_last       = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_idx_last       = IDX_W'(NUM_DIGITS - 1);

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    // Segment pattern {a,b,c,d,e,f,g}, 0 = lit.
    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    logic [0:0]                  r_state;
    logic [0:0]                  w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [IDX_W-1:0]            r_idx;
    logic [NUM_DIGITS-1:0][3:0]  r_shadow;
    logic [NUM_DIGITS-1:0]       r_shadow_dp;
    logic [NUM_DIGITS-1:0][3:0]  r_active;
    logic [NUM_DIGITS-1:0]       r_active_dp;
    logic                        r_commit_d;

    logic [6:0]                  r_seg;
    logic                        r_dp;
    logic [NUM_DIGITS-1:0]       r_dig_en_n;
    logic                        r_frame_start;

    logic                        w_slot_end;
    logic                        w_commit;
    logic                        w_idx_ok;
    logic                        w_wr_fire;
    logic                        w_dark;
    logic [6:0]                  w_seg_nxt;
    logic                        w_dp_nxt;
    logic [NUM_DIGITS-1:0]       w_dig_nxt;

    assign w_slot_end = (r_cnt == c_cnt_last);
    // The commit cycle is the last SHOW cycle of the last digit; the write
    // port stalls for exactly that cycle so a write never races the copy.
    assign w_commit   = w_slot_end && (r_idx == c_idx_last);

    assign wr_if.wr_ready = ~w_commit;

    // Out-of-range indices only exist when NUM_DIGITS is not a power of two.
    generate
        if ((1 << IDX_W) == NUM_DIGITS) begin : g_idx_pow2
            assign w_idx_ok = 1'b1;
        end else begin : g_idx_range
            assign w_idx_ok = ({1'b0, wr_if.wr_idx} < (IDX_W + 1)'(NUM_DIGITS));
        end
    endgenerate

    assign w_wr_fire = wr_if.wr_valid && wr_if.wr_ready && w_idx_ok;

    // ------------------------------------------------------------------
    // Slot counter and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_blank;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_blank: if (r_cnt == c_cnt_blank_last) w_state_nxt = c_st_show;
            c_st_show:  if (w_slot_end)                w_state_nxt = c_st_blank;
            default:                                   w_state_nxt = c_st_blank;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow / active digit buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_active    <= '0;
            r_active_dp <= '0;
            r_commit_d  <= 1'b0;
        end else begin
            r_commit_d <= w_commit;
            if (w_wr_fire) begin
                r_shadow[wr_if.wr_idx]    <= wr_if.wr_data;
                r_shadow_dp[wr_if.wr_idx] <= wr_if.wr_dp;
            end
            if (w_commit) begin
                r_active    <= r_shadow;
                r_active_dp <= r_shadow_dp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression: a digit above 0 goes dark when it and every
    // more significant digit hold value 0 with the decimal point off.
    // ------------------------------------------------------------------
`ifdef SEVENSEG_LZS_EN
    logic [NUM_DIGITS-1:0] w_zero_from;

    always_comb begin
        w_zero_from = '0;
        w_zero_from[NUM_DIGITS-1] = (r_active[NUM_DIGITS-1] == 4'h0) &&
                                    !r_active_dp[NUM_DIGITS-1];
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            w_zero_from[k] = w_zero_from[k+1] && (r_active[k] == 4'h0) &&
                             !r_active_dp[k];
        end
    end

    assign w_dark = (r_idx != '0) && w_zero_from[r_idx];
`else
    assign w_dark = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: output logic (next pin values)
    // ------------------------------------------------------------------
    always_comb begin
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        w_dig_nxt = '1;
        if (r_state == c_st_show) begin
            w_dig_nxt[r_idx] = 1'b0;
            if (!w_dark) begin
                w_seg_nxt = f_decode(r_active[r_idx]);
                w_dp_nxt  = ~r_active_dp[r_idx];
            end
        end
    end

    // Pin register: enables, segments and frame_start all move on the same
    // edge, one cycle after the state/counter that produced them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg         <= 7'h7F;
            r_dp          <= 1'b1;
            r_dig_en_n    <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_seg         <= w_seg_nxt;
            r_dp          <= w_dp_nxt;
            r_dig_en_n    <= w_dig_nxt;
            r_frame_start <= r_commit_d;
        end
    end

    assign {a, b, c, d, e, f, g} = r_seg;
    assign dp          = r_dp;
    assign dig_en_n    = r_dig_en_n;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
